// File: rtl/ledpanel_rx_pkg.sv
// ledpanel_rx_pkg
// Shared definitions for the HUB75 panel receiver: commit FSM states,
// the status register address and the status bit positions.
package ledpanel_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_TOP = 2'd1,
    ST_WR_BOT = 2'd2
  } commit_state_t;

  localparam logic [15:0] STATUS_ADDR = 16'h8000;

  localparam int BIT_OVERRUN = 31;
  localparam int BIT_COLERR  = 30;
  localparam int BIT_OE      = 29;

  // Number of panel pins brought through the synchronizer.
  localparam int SYNC_W = 13;

endpackage

// File: rtl/icosoc_ledpanel_rx_sync.sv
// icosoc_ledpanel_rx_sync
// Two-flop synchronizer for a bundle of asynchronous inputs, followed by a
// third register that holds the synchronized level and a registered
// rising-edge flag aligned with it (dout and rise change in the same cycle).
//   clk, reset : system clock, asynchronous active-high reset
//   din        : asynchronous inputs
//   dout       : synchronized levels
//   rise       : one-cycle pulse in the first cycle dout shows a 0->1 change
module icosoc_ledpanel_rx_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      dout    <= '0;
      rise    <= '0;
    end else begin
      // p0/p1: metastability filter
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // p2: level and edge, aligned
      dout    <= sync_p1;
      rise    <= sync_p1 & ~dout;
    end
  end

endmodule

// File: rtl/icosoc_mod_ledpanel_rx.sv
// icosoc_mod_ledpanel_rx
// HUB75 LED-panel receiver. Samples the panel-side signals of a ledpanel
// transmitter, shifts each line into a line buffer, and on every strobe
// commits that line into one bit-plane of a 4-bit-per-channel frame memory.
// The CPU reads pixels and a status word over the icosoc ctrl bus.
//   clk, reset          : system clock, asynchronous active-high reset
//   ctrl_wr/rd/addr/wdat: bus request (held until ctrl_done)
//   ctrl_rdat, ctrl_done: read data and one-cycle completion pulse
//   panel_r0..b1        : colour bits, top half (0) and bottom half (1)
//   panel_a..d          : row select, d is MSB
//   panel_clk, panel_stb: shift clock and line latch (rising edges used)
//   panel_oe            : output enable, reported in status only
module icosoc_mod_ledpanel_rx
  import ledpanel_rx_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 6000000,
  parameter int SIZE          = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic        panel_r0,
  input  logic        panel_g0,
  input  logic        panel_b0,
  input  logic        panel_r1,
  input  logic        panel_g1,
  input  logic        panel_b1,
  input  logic        panel_a,
  input  logic        panel_b,
  input  logic        panel_c,
  input  logic        panel_d,
  input  logic        panel_clk,
  input  logic        panel_stb,
  input  logic        panel_oe
);

  localparam int COLS      = 32 * SIZE;
  localparam int SIZE_BITS = $clog2(SIZE);
  localparam int XW        = 5 + SIZE_BITS;
  localparam int AW        = XW + 5;
  localparam int CW        = XW + 1;
  localparam int DEPTH     = SIZE * 1024;
  localparam logic [CW-1:0] COLS_C = CW'(COLS);
  localparam logic [XW-1:0] LAST_X = XW'(COLS - 1);

  // Input synchronization
  logic [SYNC_W-1:0] pin_async;
  logic [SYNC_W-1:0] pin_sync;
  logic [SYNC_W-1:0] pin_rise;

  assign pin_async = {panel_oe, panel_stb, panel_clk,
                      panel_d, panel_c, panel_b, panel_a,
                      panel_b1, panel_g1, panel_r1,
                      panel_b0, panel_g0, panel_r0};

  icosoc_ledpanel_rx_sync #(.W(SYNC_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pin_async),
    .dout  (pin_sync),
    .rise  (pin_rise)
  );

  logic [5:0] pix_bits;   // {b1, g1, r1, b0, g0, r0}
  logic [3:0] row_in;
  logic       clk_rise;
  logic       stb_rise;
  logic       oe_sync;

  assign pix_bits = pin_sync[5:0];
  assign row_in   = pin_sync[9:6];
  assign clk_rise = pin_rise[10];
  assign stb_rise = pin_rise[11];
  assign oe_sync  = pin_sync[12];

  // Control state
  logic [CW-1:0]  col_cnt;
  logic [1:0]     plane;
  logic [3:0]     last_row;
  commit_state_t  state;
  logic [XW-1:0]  x_cnt;
  logic [3:0]     commit_row;
  logic [1:0]     commit_plane;
  logic           overrun;
  logic           colerr;
  logic [15:0]    frame_cnt;

  // Line storage and frame memory (not reset)
  logic [5:0] line_buf   [COLS];
  logic [5:0] commit_buf [COLS];
  logic [3:0] mem_r [DEPTH];
  logic [3:0] mem_g [DEPTH];
  logic [3:0] mem_b [DEPTH];

  logic       accept;
  logic       shift_ok;
  logic [1:0] next_plane;
  logic       colerr_set;
  logic       overrun_set;
  logic       status_wr;
  logic       commit_last;

  // A strobe is only taken when the previous commit has drained; otherwise
  // the line is dropped and flagged.
  assign accept      = stb_rise && (state == ST_IDLE);
  assign next_plane  = (row_in == last_row) ? plane + 2'd1 : 2'd0;
  assign shift_ok    = clk_rise && !stb_rise && (col_cnt != COLS_C);
  assign colerr_set  = (stb_rise && (col_cnt != COLS_C)) ||
                       (clk_rise && !stb_rise && (col_cnt == COLS_C));
  assign overrun_set = stb_rise && (state != ST_IDLE);
  assign status_wr   = ctrl_wr && !ctrl_done && (ctrl_addr == STATUS_ADDR);
  assign commit_last = (state == ST_WR_BOT) && (x_cnt == LAST_X);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt      <= '0;
      plane        <= '0;
      last_row     <= '0;
      state        <= ST_IDLE;
      x_cnt        <= '0;
      commit_row   <= '0;
      commit_plane <= '0;
      overrun      <= 1'b0;
      colerr       <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (stb_rise) begin
        col_cnt <= '0;
      end else if (shift_ok) begin
        col_cnt <= col_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            plane        <= next_plane;
            last_row     <= row_in;
            commit_plane <= next_plane;
            commit_row   <= row_in;
            x_cnt        <= '0;
            state        <= ST_WR_TOP;
          end
        end
        ST_WR_TOP: state <= ST_WR_BOT;
        ST_WR_BOT: begin
          if (commit_last) begin
            state <= ST_IDLE;
            if (commit_row == 4'hF && commit_plane == 2'd3) begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end else begin
            x_cnt <= x_cnt + 1'b1;
            state <= ST_WR_TOP;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Hardware set takes priority over a software clear in the same cycle.
      overrun <= overrun_set | (overrun & ~(status_wr & ctrl_wdat[BIT_OVERRUN]));
      colerr  <= colerr_set  | (colerr  & ~(status_wr & ctrl_wdat[BIT_COLERR]));
    end
  end

  always_ff @(posedge clk) begin
    if (shift_ok) begin
      line_buf[col_cnt[XW-1:0]] <= pix_bits;
    end
    // Columns never clocked in this line are committed as zero.
    if (accept) begin
      for (int i = 0; i < COLS; i++) begin
        commit_buf[i] <= (CW'(i) < col_cnt) ? line_buf[i] : 6'd0;
      end
    end
    if (state == ST_WR_TOP) begin
      mem_r[{x_cnt, 1'b0, commit_row}][commit_plane] <= commit_buf[x_cnt][0];
      mem_g[{x_cnt, 1'b0, commit_row}][commit_plane] <= commit_buf[x_cnt][1];
      mem_b[{x_cnt, 1'b0, commit_row}][commit_plane] <= commit_buf[x_cnt][2];
    end
    if (state == ST_WR_BOT) begin
      mem_r[{x_cnt, 1'b1, commit_row}][commit_plane] <= commit_buf[x_cnt][3];
      mem_g[{x_cnt, 1'b1, commit_row}][commit_plane] <= commit_buf[x_cnt][4];
      mem_b[{x_cnt, 1'b1, commit_row}][commit_plane] <= commit_buf[x_cnt][5];
    end
  end

  // Bus read mux
  logic [12:0]   pix_idx;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_word;

  assign pix_idx = ctrl_addr[14:2];
  assign rd_addr = pix_idx[AW-1:0];

  always_comb begin
    rd_word = '0;
    if (!ctrl_addr[15]) begin
      if ({1'b0, pix_idx} < 14'(DEPTH)) begin
        rd_word = {8'h0, mem_r[rd_addr], 4'h0, mem_g[rd_addr], 4'h0,
                   mem_b[rd_addr], 4'h0};
      end
    end else if (ctrl_addr == STATUS_ADDR) begin
      rd_word[BIT_OVERRUN] = overrun;
      rd_word[BIT_COLERR]  = colerr;
      rd_word[BIT_OE]      = oe_sync;
      rd_word[15:0]        = frame_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end else begin
      ctrl_done <= (ctrl_wr || ctrl_rd) && !ctrl_done;
      ctrl_rdat <= (ctrl_rd && !ctrl_done) ? rd_word : 32'h0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ctrl_addr[1:0], ctrl_wdat[29:0], pin_sync[11:10],
                         pin_rise[12], pin_rise[9:0], (CLOCK_FREQ_HZ > 0)};

endmodule

// File: tb/tb_icosoc_mod_ledpanel_rx.sv
module tb_icosoc_mod_ledpanel_rx;
  import ledpanel_rx_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_wr = 1'b0;
  logic        ctrl_rd = 1'b0;
  logic [15:0] ctrl_addr = '0;
  logic [31:0] ctrl_wdat = '0;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic panel_r0 = 0, panel_g0 = 0, panel_b0 = 0;
  logic panel_r1 = 0, panel_g1 = 0, panel_b1 = 0;
  logic panel_a = 0, panel_b = 0, panel_c = 0, panel_d = 0;
  logic panel_clk = 0, panel_stb = 0, panel_oe = 0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  icosoc_mod_ledpanel_rx #(.CLOCK_FREQ_HZ(6000000), .SIZE(1)) dut (
    .clk(clk), .reset(reset),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
    .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
    .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
    .panel_a(panel_a), .panel_b(panel_b), .panel_c(panel_c), .panel_d(panel_d),
    .panel_clk(panel_clk), .panel_stb(panel_stb), .panel_oe(panel_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix_word(input logic [3:0] r, input logic [3:0] g,
                                           input logic [3:0] b);
    return {8'h0, r, 4'h0, g, 4'h0, b, 4'h0};
  endfunction

  function automatic logic [15:0] pix_addr(input int x, input int y);
    logic [4:0] xx;
    logic [4:0] yy;
    xx = x[4:0];
    yy = y[4:0];
    return {4'b0, xx, yy, 2'b00};
  endfunction

  // Loopback image bits for row rr, plane p: {b1,g1,r1,b0,g0,r0}
  function automatic logic [5:0] lb_bits(input int rr, input int p);
    logic [3:0] gt, gb, bt, bb;
    logic [1:0] pi;
    pi = p[1:0];
    gt = (rr == 0)  ? 4'd5 : 4'd4;
    gb = 4'd4;
    bt = 4'd2;
    bb = (rr == 15) ? 4'd3 : 4'd2;
    return {bb[pi], gb[pi], 1'b1, bt[pi], gt[pi], 1'b1};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    bit seen;
    seen = 0;
    data = '0;
    @(negedge clk);
    ctrl_addr = addr;
    ctrl_rd = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ctrl_done) begin
        seen = 1;
        data = ctrl_rdat;
      end
    end
    if (!seen) check("bus_read_timeout", {31'd0, ctrl_done}, 32'd1);
    @(negedge clk);
    ctrl_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] wdat);
    bit seen;
    seen = 0;
    @(negedge clk);
    ctrl_addr = addr;
    ctrl_wdat = wdat;
    ctrl_wr = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ctrl_done) seen = 1;
    end
    if (!seen) check("bus_write_timeout", {31'd0, ctrl_done}, 32'd1);
    @(negedge clk);
    ctrl_wr = 1'b0;
  endtask

  task automatic check_pix(input string tag, input int x, input int y, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(pix_addr(x, y), d);
    check(tag, d, exp);
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(STATUS_ADDR, d);
    check(tag, d, exp);
  endtask

  // One panel_clk pulse per column, 2 clk low then 2 clk high.
  task automatic shift_cols(input int n, input logic [5:0] bits);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {panel_b1, panel_g1, panel_r1, panel_b0, panel_g0, panel_r0} = bits;
      panel_clk = 1'b0;
      repeat (2) @(negedge clk);
      panel_clk = 1'b1;
      repeat (2) @(negedge clk);
      panel_clk = 1'b0;
    end
  endtask

  task automatic strobe(input logic [3:0] row);
    @(negedge clk);
    {panel_d, panel_c, panel_b, panel_a} = row;
    panel_stb = 1'b1;
    repeat (2) @(negedge clk);
    panel_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr;
    logic [31:0] d;
    logic [3:0] seq;
    logic [3:0] gexp, bexp;

    // Reset state
    cycles(3);
    check("rst_done", {31'd0, ctrl_done}, 32'd0);
    check("rst_rdat", ctrl_rdat, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycles(3);
    check_status("rst_status", 32'h0000_0000);

    // Loopback frame: rows 1..15 then 0, four planes each
    for (int k = 0; k < 16; k++) begin
      rr = (k + 1) % 16;
      for (int p = 0; p < 4; p++) begin
        shift_cols(32, lb_bits(rr, p));
        strobe(rr[3:0]);
      end
    end
    cycles(80);
    check_status("loop_status", 32'h0000_0001);
    for (int x = 0; x < 32; x++) begin
      for (int y = 0; y < 32; y++) begin
        gexp = (y == 0)  ? 4'd5 : 4'd4;
        bexp = (y == 31) ? 4'd3 : 4'd2;
        check_pix($sformatf("loop_pix_%0d_%0d", x, y), x, y, pix_word(4'hF, gexp, bexp));
      end
    end

    // Short line: 31 columns of ones into plane 0 of row 5
    shift_cols(31, 6'h3F);
    strobe(4'd5);
    cycles(80);
    check_status("short_status", 32'h4000_0001);
    check_pix("short_pix30_top", 30, 5,  pix_word(4'hF, 4'h5, 4'h3));
    check_pix("short_pix30_bot", 30, 21, pix_word(4'hF, 4'h5, 4'h3));
    check_pix("short_pix31_top", 31, 5,  pix_word(4'hE, 4'h4, 4'h2));
    check_pix("short_pix31_bot", 31, 21, pix_word(4'hE, 4'h4, 4'h2));
    bus_write(STATUS_ADDR, 32'h4000_0000);
    check_status("short_clear", 32'h0000_0001);

    // Overrun: full zero line on row 7, second strobe (row 8) 10 cycles later
    shift_cols(32, 6'h00);
    @(negedge clk);
    {panel_d, panel_c, panel_b, panel_a} = 4'd7;
    panel_stb = 1'b1;
    repeat (2) @(negedge clk);
    panel_stb = 1'b0;
    repeat (8) @(negedge clk);
    {panel_d, panel_c, panel_b, panel_a} = 4'd8;
    panel_stb = 1'b1;
    repeat (2) @(negedge clk);
    panel_stb = 1'b0;
    cycles(80);
    check_status("ovr_status", 32'hC000_0001);
    check_pix("ovr_first_x0",  0,  7,  pix_word(4'hE, 4'h4, 4'h2));
    check_pix("ovr_first_x31", 31, 23, pix_word(4'hE, 4'h4, 4'h2));
    check_pix("ovr_second",    0,  8,  pix_word(4'hF, 4'h4, 4'h2));
    bus_write(STATUS_ADDR, 32'hC000_0000);
    check_status("ovr_clear", 32'h0000_0001);

    // Plane sequencing on row 3: top r bit 1,0,1,1 across planes 0..3
    seq = 4'b1101;
    for (int p = 0; p < 4; p++) begin
      shift_cols(32, {5'b0, seq[p[1:0]]});
      strobe(4'd3);
    end
    cycles(80);
    check_pix("plane_r_d0", 0, 3,  32'h00D0_0000);
    check_pix("plane_bot",  0, 19, 32'h0000_0000);
    shift_cols(32, 6'h00);
    strobe(4'd4);
    cycles(80);
    check_pix("plane_restart", 0, 4, pix_word(4'hE, 4'h4, 4'h2));
    shift_cols(32, 6'h00);
    strobe(4'd4);
    cycles(80);
    check_pix("plane_second", 0, 4, pix_word(4'hC, 4'h4, 4'h0));
    shift_cols(32, 6'h00);
    strobe(4'd6);
    cycles(80);
    check_pix("plane_row6", 0, 6, pix_word(4'hE, 4'h4, 4'h2));
    check_status("plane_status", 32'h0000_0001);

    // Extra clock: 32 zero columns then a 33rd column of ones on row 9
    shift_cols(32, 6'h00);
    shift_cols(1, 6'h3F);
    strobe(4'd9);
    cycles(80);
    check_status("extra_status", 32'h4000_0001);
    check_pix("extra_x0",  0,  9, pix_word(4'hE, 4'h4, 4'h2));
    check_pix("extra_x31", 31, 9, pix_word(4'hE, 4'h4, 4'h2));

    // Reset mid-commit (COLERR still set from the previous line)
    shift_cols(32, 6'h3F);
    strobe(4'd10);
    cycles(19);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_done", {31'd0, ctrl_done}, 32'd0);
    check("midrst_rdat", ctrl_rdat, 32'd0);
    check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    check("midrst_colcnt", 32'(dut.col_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycles(3);
    check_status("midrst_status", 32'h0000_0000);
    check_pix("midrst_x0_top",  0,  10, pix_word(4'hF, 4'h5, 4'h3));
    check_pix("midrst_x0_bot",  0,  26, pix_word(4'hF, 4'h5, 4'h3));
    check_pix("midrst_x31_top", 31, 10, pix_word(4'hF, 4'h4, 4'h2));
    check_pix("midrst_x31_bot", 31, 26, pix_word(4'hF, 4'h4, 4'h2));

    // OE monitor, unmapped addresses, ignored pixel writes
    panel_oe = 1'b1;
    cycles(5);
    check_status("oe_high", 32'h2000_0000);
    panel_oe = 1'b0;
    cycles(5);
    check_status("oe_low", 32'h0000_0000);
    bus_read(16'h8004, d);
    check("unmapped_8004", d, 32'h0);
    bus_read(16'hFFFC, d);
    check("unmapped_fffc", d, 32'h0);
    bus_write(16'h0000, 32'hFFFF_FFFF);
    check_pix("pix_write_ignored", 0, 0, pix_word(4'hF, 4'h5, 4'h2));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icosoc_mod_ledpanel_rx.md
# icosoc_mod_ledpanel_rx

HUB75 LED-panel receiver: samples the panel-side signals that the ledpanel transmitter drives and rebuilds the 4-bit-per-channel image in a local frame memory. The CPU reads that memory back over the icosoc ctrl bus. It is used as an on-board loopback monitor and as a panel emulator in system benches. It sits on a ctrl-bus slot like any other icosoc module, and its panel inputs are wired to the pins or nets that carry the transmitter outputs.

## Interface
- CLOCK_FREQ_HZ, 6000000, system clock frequency (informational; no internal dividers).
- SIZE, 1, number of chained 32x32 panels. Columns = 32*SIZE and SIZE_BITS = $clog2(SIZE).
- clk  in  1  system clock. All state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ctrl_wr  in  1  bus write request, held until ctrl_done.
- ctrl_rd  in  1  bus read request, held until ctrl_done.
- ctrl_addr  in  16  byte address.
- ctrl_wdat  in  32  write data.
- ctrl_rdat  out  32  read data, valid while ctrl_done=1.
- ctrl_done  out  1  one-cycle completion pulse.
- panel_r0, panel_g0, panel_b0  in  1 each  top-half colour bits, asynchronous to clk.
- panel_r1, panel_g1, panel_b1  in  1 each  bottom-half colour bits, asynchronous to clk.
- panel_a, panel_b, panel_c, panel_d  in  1 each  row select; d is the MSB.
- panel_clk  in  1  shift clock; data is taken on its rising edge.
- panel_stb  in  1  latch; its rising edge commits a line.
- panel_oe  in  1  output enable, active low. Monitored only.

## Operation
- Input sync: each of the 13 panel inputs passes through a 2-flop synchronizer. Rising edges of panel_clk and panel_stb are detected on the synchronized copies. Data and row bits are used in the same synchronized cycle as the detected edge.
- Shift capture:
  - On each panel_clk rise, the 6 data bits enter a line buffer at column col_cnt, and col_cnt increments.
  - The first column clocked after a strobe is x=0.
  - col_cnt saturates at 32*SIZE. A further clock sets the COLERR flag and its data is dropped.
- Strobe handling, on each panel_stb rise:
  - row = {d,c,b,a}.
  - If row equals last_row, plane = plane+1 (mod 4); otherwise plane = 0. last_row is then set to row.
  - If col_cnt != 32*SIZE, COLERR is set; missing columns are written as 0.
  - The line buffer is copied to a commit buffer, col_cnt clears, and the commit FSM starts.
- Commit FSM:
  - States: IDLE, WR_TOP, WR_BOT.
  - IDLE -> WR_TOP on strobe.
  - WR_TOP writes bit `plane` of the pixel at {x, row}. WR_BOT writes bit `plane` of the pixel at {x, row+16}.
  - The FSM goes WR_TOP -> WR_BOT, then WR_BOT -> WR_TOP with x+1. After x = 32*SIZE-1 in WR_BOT it returns to IDLE.
  - A commit takes 64*SIZE cycles.
  - A strobe arriving while the FSM is not IDLE sets OVERRUN; that line is discarded and the running commit completes.
- Frame counter: a 16-bit count that increments, wrapping, when a commit with row=15 and plane=3 finishes.
- Memory: three arrays (r, g, b), each 4 bits x SIZE*1024 entries, indexed {x[4+SIZE_BITS:0], y[4:0]}. Memory is not reset.
- Bus:
  - ctrl_done <= (ctrl_wr||ctrl_rd) && !ctrl_done.
  - Access takes effect in the cycle where ctrl_done=1.
  - ctrl_addr[15]=0, read: pixel at ctrl_addr>>2. ctrl_rdat = {8'h0, r,4'h0, g,4'h0, b,4'h0}.
  - ctrl_addr[15]=0, write: ignored.
  - Address 0x8000, read: {OVERRUN, COLERR, oe_sync, 13'h0, frame_cnt}.
  - Address 0x8000, write: ctrl_wdat[31] clears OVERRUN and ctrl_wdat[30] clears COLERR. A same-cycle set wins over clear.
  - Any other address reads 0.
- Reset values: ctrl_done=0, ctrl_rdat=0, col_cnt=0, plane=0, last_row=0, FSM=IDLE, flags=0, frame_cnt=0, synchronizers=0.

## Timing
- Pad change to detected edge: 3 clk cycles.
- Each panel_clk high and low phase must last at least 2 clk cycles. The transmitter's clk/2 pattern run on the same clock meets this.
- Strobe edge to first memory write: 1 cycle. Last write: 64*SIZE cycles later.
- Read latency is one ctrl_done cycle. Reads of a pixel being committed in the same cycle return the old value.
- Line-rate limit: consecutive strobes must be at least 64*SIZE+1 cycles apart; closer strobes cause OVERRUN.

## Structure
- Package ledpanel_rx_pkg holds:
  - commit FSM state enum;
  - STATUS_ADDR = 16'h8000;
  - status bit positions (OVERRUN=31, COLERR=30, OE=29).
- One sub-module, icosoc_ledpanel_rx_sync: a parameterized-width 2-flop synchronizer with rising-edge detect outputs, instantiated once for all 13 inputs.

## Test plan
- Loopback: the ledpanel transmitter loaded with r=15, g=5 on y=0 else 4, b=3 on y=31 else 2, run for one full frame. Every pixel must then read r=0xF0, g=0x50/0x40, b=0x30/0x20, and frame_cnt must be 1.
- Short line: 31 panel_clk pulses then a strobe. COLERR=1 and column 31 reads 0. A write of 0x4000_0000 to 0x8000 clears COLERR.
- Overrun: two strobes 10 cycles apart. OVERRUN=1, the first line is fully written, and the second line's data is absent.
- Plane sequencing: row 3 strobed 4 times with the top r bit = 1,0,1,1. Pixel (0,3) reads r=0xD0. A strobe on row 4 then restarts at plane 0.
- Reset mid-commit: assert reset 20 cycles into a commit. All flags, counters and ctrl outputs are 0 in the next cycle and the FSM is IDLE. Memory keeps its partial contents.
- Extra clocks: 33 panel_clk pulses with SIZE=1 set COLERR, and the 33rd column is not written.
